wb_trace_fifo: RTL

Capture buffer downstream of the CPU writeback port (reg_write_enable / reg_write_addr / reg_write_data). Every committed register write is recorded in order, tagged with a sequence number, and buffered in a FIFO. Records drain through a valid/ready port to a host-side checker or UART dumper, so register-write traces can be compared against .ans files in hardware runs, not only in simulation.

---
 rtl/wb_trace_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_trace_fifo.sv
// ============================================================================
// wb_trace_fifo : writeback register-write trace capture FIFO (FWFT drain port)
// Optional build macro: WB_TRACE_SKIP_ZERO_EN (drop $0 writes before capture)
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_trace_fifo #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int SEQ_WIDTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic                     flush,
   input  logic                     reg_write_enable,
   input  logic [ADDR_WIDTH-1:0]    reg_write_addr,
   input  logic [DATA_WIDTH-1:0]    reg_write_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_WIDTH-1:0]    out_addr,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [SEQ_WIDTH-1:0]     out_seq,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [SEQ_WIDTH-1:0]     drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int REC_W = ADDR_WIDTH + DATA_WIDTH + SEQ_WIDTH;

   localparam logic [LVL_W-1:0] c_depth    = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] c_lvl_one  = LVL_W'(1);
   localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
   localparam logic [SEQ_WIDTH-1:0] c_seq_one = SEQ_WIDTH'(1);

   logic [REC_W-1:0]      mem_q [DEPTH];
   logic [REC_W-1:0]      mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic [SEQ_WIDTH-1:0]  drop_count_q, drop_count_d;
   logic                  overflow_q, overflow_d;

   logic                  capture;
   logic                  pop;
   logic                  full;
   logic                  push_ok;
   logic                  drop;
   logic [REC_W-1:0]      head_rec;

`ifdef WB_TRACE_SKIP_ZERO_EN
   // $0 writes are architecturally invisible, so they never consume a sequence number
   assign capture = reg_write_enable & trace_en & (reg_write_addr != '0);
`else
   assign capture = reg_write_enable & trace_en;
`endif

   assign out_valid = (level_q != '0);
   assign full      = (level_q == c_depth);
   assign pop       = out_valid & out_ready;
   // A full FIFO can still accept when the head leaves in the same cycle
   assign push_ok   = capture & (~full | pop);
   assign drop      = capture & full & ~pop;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      seq_d        = capture ? (seq_q + c_seq_one) : seq_q;

      if (flush) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
         end
         if (push_ok && !pop) begin
            level_d = level_q + c_lvl_one;
         end else if (pop && !push_ok) begin
            level_d = level_q - c_lvl_one;
         end
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) begin
               drop_count_d = drop_count_q + c_seq_one;
            end
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (push_ok && !flush) begin
         mem_d[wr_ptr_q] = {reg_write_addr, reg_write_data, seq_q};
      end
   end

   // Storage carries no reset; validity is governed entirely by level_q
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         seq_q        <= '0;
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         seq_q        <= seq_d;
         drop_count_q <= drop_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // Head fields are forced to zero when empty so uninitialised storage never shows
   assign head_rec   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_addr   = head_rec[REC_W-1 -: ADDR_WIDTH];
   assign out_data   = head_rec[SEQ_WIDTH +: DATA_WIDTH];
   assign out_seq    = head_rec[SEQ_WIDTH-1:0];
   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

`default_nettype wire
